// File: rtl/hlsm_pkg.sv
// Shared types and constants for the HLSM initiator.
// States and the latency counter width.
package hlsm_pkg;

  localparam int CYC_W = 16;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    START,
    ARM,
    WAIT,
    ABORT,
    HOLD
  } state_t;

endpackage

// File: rtl/hlsm_watchdog.sv
// Saturating latency counter and timeout compare.
// The counter reads k in the k-th cycle after Start.
import hlsm_pkg::*;

module hlsm_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] cnt,
  output logic             expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CYC_W'(TIMEOUT));

endmodule

// File: rtl/hlsm_initiator.sv
// Controlling-side Start/Done handshake for an HLSM datapath.
// One job in flight; a watchdog aborts a hung HLSM.
import hlsm_pkg::*;

module hlsm_initiator #(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 4,
  parameter int N_OUT   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic                    hlsm_start,
  output logic                    hlsm_rst,
  output logic [N_IN*DATA_W-1:0]  hlsm_operands,
  input  logic                    hlsm_done,
  input  logic [N_OUT*DATA_W-1:0] hlsm_results,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [CYC_W-1:0]        out_cycles,
  output logic                    out_timeout,
  output logic                    busy
);

  state_t           state_q;
  state_t           state_d;
  logic [CYC_W-1:0] cnt;
  logic             expired;

  hlsm_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (Clk),
    .rst_n  (Rst),
    .clr    (state_q == IDLE),
    .en     (state_q == START || state_q == ARM || state_q == WAIT),
    .cnt    (cnt),
    .expired(expired)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= FLUSH;
    end else begin
      state_q <= state_d;
    end
  end

  // Done in ARM is stale from the previous job and is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FLUSH: state_d = IDLE;
      IDLE:  if (in_valid) state_d = START;
      START: state_d = ARM;
      ARM:   state_d = WAIT;
      WAIT: begin
        if (hlsm_done) begin
          state_d = HOLD;
        end else if (expired) begin
          state_d = ABORT;
        end
      end
      ABORT: state_d = HOLD;
      HOLD:  if (out_ready) state_d = IDLE;
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      hlsm_operands <= '0;
      out_data      <= '0;
      out_cycles    <= '0;
      out_timeout   <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        hlsm_operands <= in_data;
      end
      if (state_q == WAIT && hlsm_done) begin
        out_data    <= hlsm_results;
        out_cycles  <= cnt;
        out_timeout <= 1'b0;
      end
      if (state_q == ABORT) begin
        out_data    <= '0;
        out_cycles  <= CYC_W'(TIMEOUT);
        out_timeout <= 1'b1;
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign hlsm_start = (state_q == START);
  assign hlsm_rst   = (state_q == FLUSH) || (state_q == ABORT);
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hlsm_initiator.sv
// Directed bench for hlsm_initiator with a behavioural
// if-statement HLSM whose Done lingers one cycle past Start.
module tb_hlsm_initiator;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int TO = 20;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               in_valid;
  logic               in_ready;
  logic [NI*DW-1:0]   in_data;
  logic               hlsm_start;
  logic               hlsm_rst;
  logic [NI*DW-1:0]   hlsm_operands;
  logic               hlsm_done;
  logic [NO*DW-1:0]   hlsm_results;
  logic               out_valid;
  logic               out_ready;
  logic [NO*DW-1:0]   out_data;
  logic [15:0]        out_cycles;
  logic               out_timeout;
  logic               busy;

  always #5 Clk = ~Clk;

  hlsm_initiator #(
    .DATA_W (DW),
    .N_IN   (NI),
    .N_OUT  (NO),
    .TIMEOUT(TO)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .hlsm_start   (hlsm_start),
    .hlsm_rst     (hlsm_rst),
    .hlsm_operands(hlsm_operands),
    .hlsm_done    (hlsm_done),
    .hlsm_results (hlsm_results),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_cycles   (out_cycles),
    .out_timeout  (out_timeout),
    .busy         (busy)
  );

  // Behavioural HLSM: if (a > b) x = a + one; else x = c - a; z = one.
  int   lat   = 12;
  bit   never = 1'b0;
  int   m_cnt = 0;
  bit   m_run = 1'b0;
  logic m_done = 1'b0;
  logic [NO*DW-1:0] m_res = '0;

  function automatic logic [63:0] hlsm_eval(input logic [127:0] op);
    logic signed [31:0] a, b, c, one, x;
    a   = op[31:0];
    b   = op[63:32];
    c   = op[95:64];
    one = op[127:96];
    if (a > b) x = a + one;
    else       x = c - a;
    return {one, x};
  endfunction

  always @(posedge Clk) begin
    if (hlsm_rst) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (hlsm_start) begin
      m_run <= 1'b1;
      m_cnt <= 1;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 1) m_done <= 1'b0;
      if (!never && m_cnt == lat - 1) begin
        m_done <= 1'b1;
        m_run  <= 1'b0;
        m_res  <= hlsm_eval(hlsm_operands);
      end
    end
  end

  assign hlsm_done    = m_done;
  assign hlsm_results = m_res;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_in_ready"}, in_ready, 1'b0);
    chk({p, "_start"}, hlsm_start, 1'b0);
    chk({p, "_hrst"}, hlsm_rst, 1'b1);
    chk({p, "_ops"}, hlsm_operands, '0);
    chk({p, "_ovalid"}, out_valid, 1'b0);
    chk({p, "_odata"}, out_data, '0);
    chk({p, "_ocyc"}, out_cycles, '0);
    chk({p, "_oto"}, out_timeout, 1'b0);
    chk({p, "_busy"}, busy, 1'b1);
  endtask

  // Called in IDLE; returns in the Start cycle T.
  task automatic accept(input logic [127:0] ops, input string p);
    in_valid = 1'b1;
    in_data  = ops;
    chk({p, "_rdy"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk({p, "_start"}, hlsm_start, 1'b1);
    chk({p, "_ops"}, hlsm_operands, ops);
  endtask

  // k = cycles after Start at which out_valid is first seen.
  task automatic wait_result(output int k, output int rst_k,
                             output int nrst, output int nstart);
    k = 0; rst_k = 0; nrst = 0; nstart = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      k = i;
      if (hlsm_rst) begin nrst++; rst_k = i; end
      if (hlsm_start) nstart++;
      if (out_valid) break;
    end
    chk("wait_bound", out_valid, 1'b1);
  endtask

  localparam logic [127:0] J1 = {32'd1, 32'd2, 32'd3, 32'd5};
  localparam logic [127:0] J2 = {32'd1, 32'd0, 32'd1, 32'hFFFF_FFFC};
  localparam logic [127:0] J3 = {32'd7, 32'd8, 32'd9, 32'd10};

  initial begin
    int k, rk, nr, ns;
    Rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk_rst("por");
    tick(); tick();
    chk_rst("por_hold");
    Rst = 1'b1;
    chk("flush_hrst", hlsm_rst, 1'b1);
    chk("flush_rdy", in_ready, 1'b0);
    tick();
    chk("idle_rdy", in_ready, 1'b1);
    chk("idle_hrst", hlsm_rst, 1'b0);
    chk("idle_busy", busy, 1'b0);

    accept(J1, "j1");
    wait_result(k, rk, nr, ns);
    chk("j1_k", k, 13);
    chk("j1_nstart", ns, 0);
    chk("j1_nrst", nr, 0);
    chk("j1_data", out_data, {32'd1, 32'd6});
    chk("j1_cyc", out_cycles, 16'd12);
    chk("j1_to", out_timeout, 1'b0);
    chk("j1_rdy", in_ready, 1'b0);
    chk("j1_busy", busy, 1'b1);
    chk("j1_ops", hlsm_operands, J1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("j1_ovalid_low", out_valid, 1'b0);
    chk("j1_stale_done", hlsm_done, 1'b1);

    accept(J2, "j2");
    wait_result(k, rk, nr, ns);
    chk("j2_k", k, 13);
    chk("j2_cyc", out_cycles, 16'd12);
    chk("j2_data", out_data, {32'd1, 32'd4});
    chk("j2_to", out_timeout, 1'b0);

    never    = 1'b1;
    in_valid = 1'b1;
    in_data  = J3;
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", out_data, {32'd1, 32'd4});
      chk("bp_rdy", in_ready, 1'b0);
      chk("bp_ovalid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bp_start", hlsm_start, 1'b1);
    chk("bp_ops", hlsm_operands, J3);

    wait_result(k, rk, nr, ns);
    chk("to_k", k, 22);
    chk("to_nrst", nr, 1);
    chk("to_rst_k", rk, 21);
    chk("to_flag", out_timeout, 1'b1);
    chk("to_data", out_data, '0);
    chk("to_cyc", out_cycles, 16'd20);
    chk("to_ops", hlsm_operands, J3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    never = 1'b0;
    lat   = 20;
    accept(J1, "col");
    wait_result(k, rk, nr, ns);
    chk("col_k", k, 21);
    chk("col_nrst", nr, 0);
    chk("col_to", out_timeout, 1'b0);
    chk("col_cyc", out_cycles, 16'd20);
    chk("col_data", out_data, {32'd1, 32'd6});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    lat = 12;
    accept(J2, "rw");
    repeat (5) tick();
    chk("rw_busy", busy, 1'b1);
    Rst = 1'b0;
    #1;
    chk_rst("rw");
    tick();
    Rst = 1'b1;
    chk("rw_flush_hrst", hlsm_rst, 1'b1);
    chk("rw_flush_rdy", in_ready, 1'b0);
    tick();
    chk("rw_idle_rdy", in_ready, 1'b1);
    chk("rw_idle_hrst", hlsm_rst, 1'b0);
    chk("rw_idle_ovalid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
